// File: rtl/div.sv
// rtl/div.sv - 32-bit multi-cycle restoring divider for DIV/DIVU.
// One quotient bit per cycle; ready_o and result_o hold in END until start_i drops.
module div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BYZERO = 2'b01;
  localparam logic [1:0] S_ON     = 2'b10;
  localparam logic [1:0] S_END    = 2'b11;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH:0] sreg;
  logic [WIDTH-1:0] divisor;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] op1_abs;
  logic [WIDTH-1:0] op2_abs;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  // Upper window minus divisor; bit WIDTH set means the subtraction borrowed.
  assign trial = {1'b0, sreg[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

  assign quo     = sreg[WIDTH-1:0];
  assign rem     = sreg[2*WIDTH:WIDTH+1];
  assign quo_fix = neg_q ? (~quo + 1'b1) : quo;
  assign rem_fix = neg_r ? (~rem + 1'b1) : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      sreg     <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            sreg    <= {WIDTH'(0), op1_abs, 1'b0};
            divisor <= op2_abs;
            neg_q   <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r   <= signed_div_i && opdata1_i[WIDTH-1];
            cnt     <= '0;
            state   <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            state <= S_FREE;
          end else begin
            state    <= S_END;
            ready_o  <= 1'b1;
            result_o <= '0;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state <= S_FREE;
          end else if (cnt != CW'(WIDTH)) begin
            if (trial[WIDTH]) begin
              sreg <= {sreg[2*WIDTH-1:0], 1'b0};
            end else begin
              sreg <= {trial[WIDTH-1:0], sreg[WIDTH-1:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end else begin
            state    <= S_END;
            ready_o  <= 1'b1;
            result_o <= {rem_fix, quo_fix};
          end
        end
        S_END: begin
          if (!start_i) begin
            state    <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - self-checking bench for div: arithmetic reference model plus directed vectors.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference quotient/remainder from plain 64-bit arithmetic (truncating division).
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: a pending result becomes visible after a fixed cycle count.
  int          m_cd;
  bit          m_done;
  logic        m_ready;
  logic [63:0] m_result;
  logic [63:0] m_pend;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cd     <= 0;
      m_done   <= 1'b0;
      m_ready  <= 1'b0;
      m_result <= 64'd0;
      m_pend   <= 64'd0;
    end else if (m_done) begin
      if (!start_i) begin
        m_done   <= 1'b0;
        m_ready  <= 1'b0;
        m_result <= 64'd0;
      end
    end else if (m_cd > 0) begin
      if (annul_i) begin
        m_cd <= 0;
      end else begin
        m_cd <= m_cd - 1;
        if (m_cd == 1) begin
          m_done   <= 1'b1;
          m_ready  <= 1'b1;
          m_result <= m_pend;
        end
      end
    end else if (start_i && !annul_i) begin
      m_pend <= ref_div(signed_div_i, opdata1_i, opdata2_i);
      m_cd   <= (opdata2_i == 32'd0) ? 1 : 33;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("cmp_ready", {63'd0, ready_o}, {63'd0, m_ready});
      chk("cmp_result", result_o, m_result);
    end
  end

  // Starts a division at a falling edge, scrambles operands after capture, checks latency/result.
  task automatic do_div(input bit wait_first, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input int hold);
    int cyc;
    bit got;
    if (wait_first) @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 60 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      if (ready_o) got = 1'b1;
    end
    chk("latency", 64'(cyc - 1), 64'(lat));
    chk("result", result_o, exp);
    chk("model_pin", ref_div(sgn, a, b), exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("ready_held", {63'd0, ready_o}, 64'd1);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("ready_drop", {63'd0, ready_o}, 64'd0);
  endtask

  int rises;

  initial begin
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    rst = 1'b1;

    do_div(1'b1, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0);
    do_div(1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    do_div(1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0);
    do_div(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);
    do_div(1'b1, 1'b0, 32'd5, 32'd0, 64'd0, 1, 3);
    do_div(1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33, 1);

    // Annul at iteration 10; start drops with it so FREE does not relaunch.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    rises = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) rises++;
    end
    chk("annul_no_ready", 64'(rises), 64'd0);
    do_div(1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 33, 0);

    // Asynchronous reset at iteration 20, then a start on the first edge after release.
    @(negedge clk);
    opdata1_i = 32'd12345;
    opdata2_i = 32'd67;
    start_i   = 1'b1;
    repeat (21) @(negedge clk);
    #2 rst = 1'b0;
    start_i = 1'b0;
    #1;
    chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    rises = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready_o) rises++;
    end
    chk("rst_no_ready", 64'(rises), 64'd0);
    rst = 1'b1;
    do_div(1'b0, 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

    for (int k = 0; k < 4; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> (k * 7);
      b = b | 32'd1;
      do_div(1'b1, k[0], a, b, ref_div(k[0], a, b), 33, 0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
